result_twos_to_bcd: RTL

Output-side counterpart of the operand two's-complement stage. Takes a signed two's-complement result from the multiplier datapath and converts it to sign + magnitude. Negative values are negated bit-serially (invert, carry-in 1), mirroring the operand path. The magnitude is then converted to three BCD digits by iterative shift-add-3 (double dabble) for the display driver, using a start/done handshake.

---
 rtl/calc_pkg.sv | 10 +
 rtl/result_twos_to_bcd_bcd_digit_adjust.sv | 9 +
 rtl/result_twos_to_bcd.sv | 116 +++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states and BCD conversion constants
package calc_pkg;
    typedef enum logic [1:0] {IDLE, NEGATE, CONVERT, DONE} state_t;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_W-1:0] BCD_ADJ_VALUE = 4'd3;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/result_twos_to_bcd_bcd_digit_adjust.sv
// bcd_digit_adjust: add 3 to a BCD nibble that is 5 or more before the next shift
module bcd_digit_adjust
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);
    assign digit_out = (digit_in >= BCD_ADJ_THRESHOLD) ? digit_in + BCD_ADJ_VALUE : digit_in;
endmodule

// File: rtl/result_twos_to_bcd.sv
// result_twos_to_bcd: bit-serial two's-complement to sign/magnitude, then double-dabble to 3 BCD digits
module result_twos_to_bcd
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] result_in,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [WIDTH-1:0] magnitude,
    output logic [BCD_W-1:0] bcd_hundreds,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_units
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] mag_r;
    logic             sign_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [BCD_W-1:0] h_r, t_r, u_r;
    logic [BCD_W-1:0] h_a, t_a, u_a;
    logic [BCD_W-1:0] nxt_h, nxt_t, nxt_u;
    logic             neg_bit;
    logic             neg_out;
    logic [WIDTH-1:0] nxt_mag;

    bcd_digit_adjust u_adj_h (.digit_in(h_r), .digit_out(h_a));
    bcd_digit_adjust u_adj_t (.digit_in(t_r), .digit_out(t_a));
    bcd_digit_adjust u_adj_u (.digit_in(u_r), .digit_out(u_a));

    assign busy = (state == NEGATE) || (state == CONVERT);
    assign done = (state == DONE);

    // Serial negate step (LSB first, shifted in from the top) and the next double-dabble shift
    always_comb begin
        neg_bit = sign_r ? ~shift_r[0] : shift_r[0];
        neg_out = neg_bit ^ carry;
        nxt_mag = {neg_out, mag_r[WIDTH-1:1]};
        nxt_h   = {h_a[BCD_W-2:0], t_a[BCD_W-1]};
        nxt_t   = {t_a[BCD_W-2:0], u_a[BCD_W-1]};
        nxt_u   = {u_a[BCD_W-2:0], shift_r[WIDTH-1]};
    end

    // Control FSM with datapath; shift_r holds the input while negating, then the magnitude while converting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shift_r      <= '0;
            mag_r        <= '0;
            sign_r       <= 1'b0;
            carry        <= 1'b0;
            cnt          <= '0;
            h_r          <= '0;
            t_r          <= '0;
            u_r          <= '0;
            sign         <= 1'b0;
            magnitude    <= '0;
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_units    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        shift_r <= result_in;
                        sign_r  <= result_in[WIDTH-1];
                        carry   <= result_in[WIDTH-1];
                        cnt     <= '0;
                        state   <= NEGATE;
                    end else begin
                        state <= IDLE;
                    end
                end
                NEGATE: begin
                    carry <= neg_bit & carry;
                    mag_r <= nxt_mag;
                    if (cnt == LAST) begin
                        shift_r <= nxt_mag;
                        h_r     <= '0;
                        t_r     <= '0;
                        u_r     <= '0;
                        cnt     <= '0;
                        state   <= CONVERT;
                    end else begin
                        shift_r <= shift_r >> 1;
                        cnt     <= cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    h_r     <= nxt_h;
                    t_r     <= nxt_t;
                    u_r     <= nxt_u;
                    shift_r <= shift_r << 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sign         <= sign_r;
                        magnitude    <= mag_r;
                        bcd_hundreds <= nxt_h;
                        bcd_tens     <= nxt_t;
                        bcd_units    <= nxt_u;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
